uart2fifo: RTL and testbench

- Receive-side counterpart of fifo2uart: accepts bytes from uart_rx over its valid/ready handshake and writes them into the write port of the shared byte FIFO.
- Frames the stream into lines terminated by LF, optionally strips CR, and enforces a maximum line length.
- Reports per-line status: completion pulse, length, error flag and a running line count.

---
 rtl/uart2fifo.sv | 67 ++++++
 tb/tb_uart2fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart2fifo.sv
// uart2fifo: frames uart_rx bytes into TERM-terminated lines, writes them to the byte FIFO and reports per-line status
module uart2fifo #(
    parameter int         MAX_LEN  = 64,
    parameter bit         STRIP_CR = 1'b1,
    parameter logic [7:0] TERM     = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_din,
    output logic        line_done,
    output logic [7:0]  line_len,
    output logic        line_err,
    output logic [15:0] line_cnt
);
    typedef enum logic {RECV, DROP} state_t;
    localparam logic [7:0] MAX = 8'(MAX_LEN);
    state_t     state;
    logic [7:0] len;
    logic       acc;
    logic       is_term;
    logic       is_cr;
    // a pending write blocks the next accept, so the one-cycle-late full flag never overflows the FIFO
    assign rx_data_ready = !rst && !fifo_full && !fifo_wr_en;
    assign acc           = rx_data_valid && rx_data_ready;
    assign is_term       = rx_data == TERM;
    assign is_cr         = STRIP_CR && rx_data == 8'h0D;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RECV;
            len        <= 8'd0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= 8'd0;
            line_done  <= 1'b0;
            line_len   <= 8'd0;
            line_err   <= 1'b0;
            line_cnt   <= 16'd0;
        end else begin
            fifo_wr_en <= 1'b0;
            line_done  <= 1'b0;
            if (acc) begin
                if (is_term) begin
                    fifo_wr_en <= 1'b1;
                    fifo_din   <= rx_data;
                    line_done  <= 1'b1;
                    line_len   <= state == DROP ? MAX : len;
                    line_err   <= state == DROP;
                    line_cnt   <= line_cnt + 16'd1;
                    len        <= 8'd0;
                    state      <= RECV;
                end else if (state == RECV && !is_cr) begin
                    if (len < MAX) begin
                        fifo_wr_en <= 1'b1;
                        fifo_din   <= rx_data;
                        len        <= len + 8'd1;
                    end else begin
                        state <= DROP;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart2fifo.sv
// tb_uart2fifo: table-driven and randomized checks of two uart2fifo configurations against a line-level model
module tb_uart2fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        fifo_full = 1'b0;
    logic        rdy0, rdy1, wr0, wr1, done0, done1, err0, err1;
    logic [7:0]  din0, din1, len0, len1;
    logic [15:0] cnt0, cnt1;
    int cmp = 0;
    int bad = 0;
    bit rnd_en = 1'b0;

    always #5 clk = ~clk;

    uart2fifo u0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(valid0), .rx_data_ready(rdy0),
        .fifo_full(fifo_full), .fifo_wr_en(wr0), .fifo_din(din0), .line_done(done0),
        .line_len(len0), .line_err(err0), .line_cnt(cnt0)
    );
    uart2fifo #(.MAX_LEN(4), .STRIP_CR(1'b0)) u1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(valid1), .rx_data_ready(rdy1),
        .fifo_full(fifo_full), .fifo_wr_en(wr1), .fifo_din(din1), .line_done(done1),
        .line_len(len1), .line_err(err1), .line_cnt(cnt1)
    );

    task automatic chk(input string name, input int act, input int exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // line-level reference model: a line's kept bytes are truncated to MAX_LEN, then TERM follows
    int         kept_n[2];
    logic [7:0] kept[2][64];
    int         mcnt[2];
    logic [7:0] exp_f[2][2048];
    int         exp_n[2];
    int         el_len[2][512];
    int         el_err[2][512];
    int         el_cnt[2][512];
    int         el_n[2];
    logic [7:0] act_f[2][2048];
    int         act_n[2];
    int         act_lines[2];
    bit         prev_acc[2];
    logic [7:0] prev_byte[2];

    function automatic int maxl(input int s);
        return s == 1 ? 4 : 64;
    endfunction

    task automatic flush_line(input int s);
        int l;
        l = kept_n[s] > maxl(s) ? maxl(s) : kept_n[s];
        for (int j = 0; j < l; j++) begin
            exp_f[s][exp_n[s]] = kept[s][j];
            exp_n[s]++;
        end
    endtask

    task automatic model_byte(input int s, input logic [7:0] b);
        if (b == 8'h0A) begin
            flush_line(s);
            exp_f[s][exp_n[s]] = b;
            exp_n[s]++;
            mcnt[s] = (mcnt[s] + 1) & 16'hFFFF;
            el_len[s][el_n[s]] = kept_n[s] > maxl(s) ? maxl(s) : kept_n[s];
            el_err[s][el_n[s]] = int'(kept_n[s] > maxl(s));
            el_cnt[s][el_n[s]] = mcnt[s];
            el_n[s]++;
            kept_n[s] = 0;
        end else if (!(s == 0 && b == 8'h0D)) begin
            if (kept_n[s] < maxl(s)) kept[s][kept_n[s]] = b;
            kept_n[s]++;
        end
    endtask

    task automatic model_rst(input int s);
        flush_line(s);
        kept_n[s] = 0;
        mcnt[s] = 0;
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            logic wr, done, rdy, v;
            logic [7:0] din, ln;
            logic ler;
            logic [15:0] lc;
            wr = s ? wr1 : wr0;   done = s ? done1 : done0;  rdy = s ? rdy1 : rdy0;
            v = s ? valid1 : valid0;  din = s ? din1 : din0;  ln = s ? len1 : len0;
            ler = s ? err1 : err0;    lc = s ? cnt1 : cnt0;
            chk("ready_rule", int'(rdy), int'(!rst && !fifo_full && wr !== 1'b1));
            if (wr === 1'b1) begin
                chk("wr_latency", int'(prev_acc[s]), 1);
                chk("wr_data", int'(din), int'(prev_byte[s]));
                act_f[s][act_n[s]] = din;
                act_n[s]++;
            end
            if (done === 1'b1) begin
                chk("done_after_term", int'(prev_acc[s] && prev_byte[s] == 8'h0A), 1);
                if (act_lines[s] < el_n[s]) begin
                    chk("line_len", int'(ln), el_len[s][act_lines[s]]);
                    chk("line_err", int'(ler), el_err[s][act_lines[s]]);
                    chk("line_cnt", int'(lc), el_cnt[s][act_lines[s]]);
                end else chk("extra_line_done", 1, 0);
                act_lines[s]++;
            end
            prev_acc[s] = 1'b0;
            if (rst) model_rst(s);
            else if (v && rdy) begin
                model_byte(s, rx_data);
                prev_acc[s] = 1'b1;
                prev_byte[s] = rx_data;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) fifo_full = ($urandom % 4) == 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid0 = 1'b0;
        valid1 = 1'b0;
        repeat (n) step();
    endtask

    // leaves valid high so consecutive calls present back-to-back bytes
    task automatic send_byte(input int s, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data = b;
        valid0 = s == 0;
        valid1 = s == 1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (s == 1 ? rdy1 : rdy0) ok = 1'b1;
            step();
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_str(input int s, input string t);
        for (int i = 0; i < t.len(); i++) send_byte(s, t[i]);
        idle(3);
    endtask

    typedef struct {
        int    sel;
        string txt;
        int    len;
        int    err;
    } vec_t;
    vec_t vecs[10];
    logic [7:0] u1_exp[12];

    initial begin
        bit stuck;
        int nb;
        vecs[0] = '{0, "HELLO\015\n", 5, 0};
        vecs[1] = '{1, "HI\015\n", 3, 0};
        vecs[2] = '{1, "ABCDEFG\n", 4, 1};
        vecs[3] = '{1, "XY\n", 2, 0};
        vecs[4] = '{0, "\n", 0, 0};
        vecs[5] = '{1, "ABCD\n", 4, 0};
        vecs[6] = '{1, "ABCDE\n", 4, 1};
        vecs[7] = '{1, "ABCD\015\n", 4, 1};
        vecs[8] = '{0, "A\015B\015\n", 2, 0};
        vecs[9] = '{1, "\015\015\n", 2, 0};
        u1_exp = '{8'h48, 8'h49, 8'h0D, 8'h0A, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0A, 8'h58, 8'h59, 8'h0A};

        repeat (3) step();
        chk("rst_ready", int'(rdy0), 0);
        chk("rst_wr_en", int'(wr0), 0);
        chk("rst_din", int'(din0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_len", int'(len0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_cnt", int'(cnt0), 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", int'(rdy0), 1);

        foreach (vecs[i]) begin
            send_str(vecs[i].sel, vecs[i].txt);
            chk($sformatf("vec%0d_len", i), int'(vecs[i].sel ? len1 : len0), vecs[i].len);
            chk($sformatf("vec%0d_err", i), int'(vecs[i].sel ? err1 : err0), vecs[i].err);
            if (i == 3) begin
                chk("u1_cnt_after_xy", int'(cnt1), 3);
                for (int j = 0; j < 12; j++) chk($sformatf("u1_fifo%0d", j), int'(act_f[1][j]), int'(u1_exp[j]));
            end
        end
        for (int j = 0; j < 6; j++) chk($sformatf("hello_fifo%0d", j), int'(act_f[0][j]), int'(j < 5 ? "HELLO" >> (8 * (4 - j)) & 255 : 10));

        // full held: Z must wait, then be accepted the cycle full drops and written one cycle later
        fifo_full = 1'b1;
        rx_data = "Z";
        valid0 = 1'b1;
        stuck = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (rdy0 || wr0) stuck = 1'b1;
            step();
        end
        chk("full_blocks", int'(stuck), 0);
        fifo_full = 1'b0;
        @(negedge clk);
        chk("z_ready", int'(rdy0), 1);
        step();
        valid0 = 1'b0;
        @(negedge clk);
        chk("z_wr", int'(wr0), 1);
        chk("z_din", int'(din0), 8'h5A);
        step();
        send_str(0, "\n");
        chk("z_line_len", int'(len0), 1);

        // reset mid-line
        send_str(0, "ABC");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(rdy0), 0);
        step();
        rst = 1'b0;
        chk("midrst_cnt0", int'(cnt0), 0);
        chk("midrst_cnt1", int'(cnt1), 0);
        chk("midrst_len", int'(len0), 0);
        chk("midrst_wr", int'(wr0), 0);
        chk("midrst_din", int'(din0), 0);
        send_str(0, "D\n");
        chk("after_rst_len", int'(len0), 1);
        chk("after_rst_cnt", int'(cnt0), 1);

        // random back-to-back lines with a randomly toggling full flag
        rnd_en = 1'b1;
        for (int r = 0; r < 60; r++) begin
            int s;
            s = $urandom % 2;
            nb = $urandom_range(0, 9);
            for (int k = 0; k < nb; k++)
                send_byte(s, ($urandom % 8) == 0 ? 8'h0D : 8'(8'h61 + $urandom % 26));
            send_byte(s, 8'h0A);
        end
        rnd_en = 1'b0;
        step();
        fifo_full = 1'b0;
        idle(5);

        for (int s = 0; s < 2; s++) begin
            chk($sformatf("fifo_count%0d", s), act_n[s], exp_n[s]);
            chk($sformatf("line_count%0d", s), act_lines[s], el_n[s]);
            for (int j = 0; j < exp_n[s] && j < act_n[s]; j++)
                chk($sformatf("fifo%0d_byte%0d", s, j), int'(act_f[s][j]), int'(exp_f[s][j]));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
